// File: rtl/cherry_dma_pkg.sv
// rtl/cherry_dma_pkg.sv - shared widths, instruction layout and FSM states for the DMA scheduler
package cherry_dma_pkg;

    localparam int INSTR_W = 22;
    localparam int DATA_W  = 18;
    localparam int ADDR_W  = 7;
    localparam int REG_W   = 5;
    localparam int LEN_W   = 5;

    localparam int BIT_VALID = 21;
    localparam int BIT_WRITE = 20;
    localparam int ADDR_LSB  = 13;
    localparam int SRC_LSB   = 8;
    localparam int LEN_LSB   = 3;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        FETCH,
        ISSUE,
        SETTLE,
        WAIT
    } dma_state_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  src;
        logic [LEN_W-1:0]  len;
        logic [2:0]        rsvd;
    } dma_instr_t;

    function automatic dma_instr_t mk_instr(input logic v, input logic w,
                                            input logic [ADDR_W-1:0] a,
                                            input logic [REG_W-1:0] s,
                                            input logic [LEN_W-1:0] l);
        dma_instr_t t;
        t.valid = v;
        t.write = w;
        t.addr  = a;
        t.src   = s;
        t.len   = l;
        t.rsvd  = 3'b000;
        return t;
    endfunction

endpackage

// File: rtl/dma_sched_if.sv
// rtl/dma_sched_if.sv - queue, register-file and dma_uart signals of the DMA scheduler
interface dma_sched_if;
    import cherry_dma_pkg::*;

    logic              qa_empty;
    dma_instr_t        qa_instr;
    logic              qa_re;
    logic              qb_empty;
    dma_instr_t        qb_instr;
    logic              qb_re;
    logic [REG_W-1:0]  rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              dma_we;
    logic [DATA_W-1:0] dma_dat_w;
    logic [ADDR_W-1:0] dma_dat_addr;
    logic              dma_busy;
    logic              freeze;
    logic              done;
    logic              err;
    logic              grant_b;

    modport master (
        input  qa_empty, qa_instr, qb_empty, qb_instr, rf_rdata, dma_busy,
        output qa_re, qb_re, rf_raddr, dma_we, dma_dat_w, dma_dat_addr,
               freeze, done, err, grant_b
    );

    modport slave (
        output qa_empty, qa_instr, qb_empty, qb_instr, rf_rdata, dma_busy,
        input  qa_re, qb_re, rf_raddr, dma_we, dma_dat_w, dma_dat_addr,
               freeze, done, err, grant_b
    );

endinterface

// File: rtl/dma_rr_arb2.sv
// rtl/dma_rr_arb2.sv - two-way round-robin grant; remembers the last winner only when enabled
module dma_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_last_b;
    logic w_pick_b;

    // B wins when it is alone, or when both ask and A won last time
    assign w_pick_b = i_req_b && (!i_req_a || !r_last_b);
    assign o_gnt_b  = i_en && w_pick_b;
    assign o_gnt_a  = i_en && i_req_a && !w_pick_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_b <= 1'b1;
        end else if (i_en && (i_req_a || i_req_b)) begin
            r_last_b <= w_pick_b;
        end
    end

endmodule

// File: rtl/dma_sched.sv
// rtl/dma_sched.sv - arbitrates two DMA instruction queues and expands each into dma_uart word writes
module dma_sched
    import cherry_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    dma_sched_if.master bus
);

    dma_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_base;
    logic [REG_W-1:0]  r_src;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic              r_grant_b;
    logic              r_live;
    logic              r_err;
    logic [REG_W-1:0]  r_rf_raddr;
    logic [DATA_W-1:0] r_dat_w;
    logic [ADDR_W-1:0] r_dat_addr;

    logic              w_arb_en, w_gnt_a, w_gnt_b, w_pop;
    logic              w_valid, w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [REG_W-1:0]  w_src;
    logic [LEN_W-1:0]  w_len;
    logic              w_issue, w_last, w_wait_go;

    // r_live keeps the pops quiet for the first cycle out of reset
    assign w_arb_en = r_live && (r_state == IDLE);

    dma_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_arb_en),
        .i_req_a (!bus.qa_empty),
        .i_req_b (!bus.qb_empty),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign w_pop   = w_gnt_a || w_gnt_b;
    assign w_valid = r_grant_b ? bus.qb_instr.valid : bus.qa_instr.valid;
    assign w_write = r_grant_b ? bus.qb_instr.write : bus.qa_instr.write;
    assign w_addr  = r_grant_b ? bus.qb_instr.addr  : bus.qa_instr.addr;
    assign w_src   = r_grant_b ? bus.qb_instr.src   : bus.qa_instr.src;
    assign w_len   = r_grant_b ? bus.qb_instr.len   : bus.qa_instr.len;

    assign w_issue   = (r_state == ISSUE) && !bus.dma_busy;
    assign w_wait_go = (r_state == WAIT) && !bus.dma_busy;
    assign w_last    = (r_beat == r_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_next = LATCH;
            LATCH:   w_next = (w_valid && w_write) ? FETCH : IDLE;
            FETCH:   w_next = ISSUE;
            ISSUE:   if (!bus.dma_busy) w_next = SETTLE;
            SETTLE:  w_next = WAIT;
            WAIT:    if (!bus.dma_busy) w_next = w_last ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base     <= '0;
            r_src      <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_grant_b  <= 1'b0;
            r_live     <= 1'b0;
            r_err      <= 1'b0;
            r_rf_raddr <= '0;
            r_dat_w    <= '0;
            r_dat_addr <= '0;
        end else begin
            r_live <= 1'b1;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: r_grant_b <= w_gnt_b;
                LATCH: begin
                    if (w_valid && w_write) begin
                        r_base     <= w_addr;
                        r_src      <= w_src;
                        r_len      <= w_len;
                        r_beat     <= '0;
                        r_rf_raddr <= w_src;
                    end else begin
                        r_err     <= w_valid;
                        r_grant_b <= 1'b0;
                    end
                end
                // address is ready for the whole ISSUE cycle; both sums wrap naturally
                FETCH: r_dat_addr <= r_base + ADDR_W'(r_beat);
                ISSUE: if (!bus.dma_busy) r_dat_w <= bus.rf_rdata;
                WAIT: begin
                    if (!bus.dma_busy) begin
                        if (w_last) begin
                            r_grant_b <= 1'b0;
                        end else begin
                            r_beat     <= r_beat + LEN_W'(1);
                            r_rf_raddr <= r_src + REG_W'(r_beat) + REG_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.qa_re        = w_gnt_a;
    assign bus.qb_re        = w_gnt_b;
    assign bus.rf_raddr     = r_rf_raddr;
    assign bus.dma_we       = w_issue;
    // rf_rdata is itself registered by the register file; the register holds it afterwards
    assign bus.dma_dat_w    = (r_state == ISSUE) ? bus.rf_rdata : r_dat_w;
    assign bus.dma_dat_addr = r_dat_addr;
    assign bus.freeze       = w_pop || (r_state != IDLE) || bus.dma_busy;
    assign bus.done         = w_wait_go && w_last;
    assign bus.err          = r_err;
    assign bus.grant_b      = r_grant_b;

endmodule

// File: tb/tb_dma_sched.sv
// tb/tb_dma_sched.sv - directed checks of dma_sched against queue, register-file and dma_uart models
module tb_dma_sched;
    import cherry_dma_pkg::*;

    localparam int BUSY_LEN = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dma_sched_if bus ();

    dma_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    dma_instr_t qa_mem[32];
    dma_instr_t qb_mem[32];
    int qa_head = 0, qa_tail = 0, qb_head = 0, qb_tail = 0;
    logic [DATA_W-1:0] rf[32];
    int busy_cnt;
    logic force_busy = 1'b0;

    int wr_addr[$], wr_data[$], wr_raddr[$], wr_gb[$], wr_cyc[$];
    int pop_b[$], pop_cyc[$];
    int n_done = 0, n_err = 0, done_cyc = 0, done_frz = 0, bad_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.qa_empty = (qa_head == qa_tail);
    assign bus.qb_empty = (qb_head == qb_tail);
    assign bus.dma_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        if (bus.qa_re) begin
            bus.qa_instr <= qa_mem[qa_head];
            qa_head <= qa_head + 1;
        end
        if (bus.qb_re) begin
            bus.qb_instr <= qb_mem[qb_head];
            qb_head <= qb_head + 1;
        end
        bus.rf_rdata <= rf[bus.rf_raddr];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)               busy_cnt <= 0;
        else if (bus.dma_we)      busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (bus.dma_we) begin
            wr_addr.push_back(int'(bus.dma_dat_addr));
            wr_data.push_back(int'(bus.dma_dat_w));
            wr_raddr.push_back(int'(bus.rf_raddr));
            wr_gb.push_back(int'(bus.grant_b));
            wr_cyc.push_back(cyc);
        end
        if (bus.qa_re || bus.qb_re) begin
            pop_b.push_back(int'(bus.qb_re));
            pop_cyc.push_back(cyc);
        end
        if ((bus.qa_re && bus.qa_empty) || (bus.qb_re && bus.qb_empty)) bad_pop <= bad_pop + 1;
        if (bus.done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
            done_frz <= int'(bus.freeze);
        end
        if (bus.err) n_err <= n_err + 1;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {27'd0, bus.qa_re, bus.qb_re, bus.dma_we, bus.freeze, bus.done, bus.err,
                bus.grant_b, bus.rf_raddr, bus.dma_dat_addr, bus.dma_dat_w};
    endfunction

    task automatic push(input logic to_b, input dma_instr_t ins);
        if (to_b) begin
            qb_mem[qb_tail] = ins;
            qb_tail++;
        end else begin
            qa_mem[qa_tail] = ins;
            qa_tail++;
        end
    endtask

    task automatic wait_quiet(input string tag);
        int calm = 0;
        for (int i = 0; i < 3000 && calm < 3; i++) begin
            @(negedge clk);
            if (bus.qa_empty && bus.qb_empty && !bus.freeze) calm++;
            else calm = 0;
        end
        if (calm < 3) chk_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        force_busy = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int w0, p0, d0, e0;
        logic seen;
        int exp_a[4];
        int exp_r[4];

        for (int i = 0; i < 32; i++) rf[i] = DATA_W'(1000 + 7 * i);
        rf[3] = 18'd34133;

        // reset state
        @(negedge clk);
        chk_eq("reset_outs", outs(), 0);
        reset = 1'b1;

        // 1: single beat, pop-to-write latency and done after busy falls
        @(posedge clk); #1;
        push(1'b0, mk_instr(1, 1, 7'd120, 5'd3, 5'd0));
        wait_quiet("t1");
        chk_eq("t1_writes", wr_addr.size(), 1);
        chk_eq("t1_addr", wr_addr[0], 120);
        chk_eq("t1_data", wr_data[0], 34133);
        chk_eq("t1_pops", pop_b.size(), 1);
        chk_eq("t1_latency", wr_cyc[0] - pop_cyc[0], 3);
        chk_eq("t1_done_cnt", n_done, 1);
        chk_eq("t1_done_lat", done_cyc - wr_cyc[0], 1 + BUSY_LEN);
        chk_eq("t1_done_frz", done_frz, 1);

        // 2: both queues loaded -> alternating grants, A first after reset
        do_reset();
        w0 = wr_addr.size();
        p0 = pop_b.size();
        @(posedge clk); #1;
        push(1'b0, mk_instr(1, 1, 7'd10, 5'd1, 5'd0));
        push(1'b0, mk_instr(1, 1, 7'd11, 5'd1, 5'd0));
        push(1'b1, mk_instr(1, 1, 7'd20, 5'd2, 5'd0));
        push(1'b1, mk_instr(1, 1, 7'd21, 5'd2, 5'd0));
        wait_quiet("t2");
        exp_a = '{10, 20, 11, 21};
        exp_r = '{0, 1, 0, 1};
        chk_eq("t2_writes", wr_addr.size() - w0, 4);
        for (int k = 0; k < 4; k++) begin
            chk_eq($sformatf("t2_pop%0d", k), pop_b[p0 + k], exp_r[k]);
            chk_eq($sformatf("t2_addr%0d", k), wr_addr[w0 + k], exp_a[k]);
            chk_eq($sformatf("t2_gntb%0d", k), wr_gb[w0 + k], exp_r[k]);
        end
        chk_eq("t2_data0", wr_data[w0], 1007);
        chk_eq("t2_data1", wr_data[w0 + 1], 1014);

        // 3: four-beat burst wrapping both address and source index
        w0 = wr_addr.size();
        d0 = n_done;
        @(posedge clk); #1;
        push(1'b0, mk_instr(1, 1, 7'd126, 5'd30, 5'd3));
        wait_quiet("t3");
        exp_a = '{126, 127, 0, 1};
        exp_r = '{30, 31, 0, 1};
        chk_eq("t3_writes", wr_addr.size() - w0, 4);
        for (int k = 0; k < 4; k++) begin
            chk_eq($sformatf("t3_addr%0d", k), wr_addr[w0 + k], exp_a[k]);
            chk_eq($sformatf("t3_raddr%0d", k), wr_raddr[w0 + k], exp_r[k]);
            chk_eq($sformatf("t3_data%0d", k), wr_data[w0 + k], 1000 + 7 * exp_r[k]);
        end
        chk_eq("t3_done", n_done - d0, 1);

        // 4: read request flags err, invalid entry is silent
        w0 = wr_addr.size();
        p0 = pop_b.size();
        d0 = n_done;
        e0 = n_err;
        @(posedge clk); #1;
        push(1'b0, mk_instr(1, 0, 7'd50, 5'd4, 5'd2));
        push(1'b0, mk_instr(0, 1, 7'd51, 5'd4, 5'd2));
        wait_quiet("t4");
        chk_eq("t4_pops", pop_b.size() - p0, 2);
        chk_eq("t4_err", n_err - e0, 1);
        chk_eq("t4_writes", wr_addr.size() - w0, 0);
        chk_eq("t4_done", n_done - d0, 0);

        // 5: dma_busy held high across ISSUE for 20 cycles
        w0 = wr_addr.size();
        @(posedge clk); #1;
        push(1'b0, mk_instr(1, 1, 7'd40, 5'd5, 5'd0));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.qa_re;
        end
        chk_eq("t5_pop_seen", seen, 1);
        @(posedge clk); #1;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.dma_we || !bus.freeze) seen = 1'b1;
        end
        chk_eq("t5_hold_quiet", seen, 0);
        @(posedge clk); #1;
        force_busy = 1'b0;
        @(negedge clk);
        chk_eq("t5_we_release", bus.dma_we, 1);
        chk_eq("t5_addr", bus.dma_dat_addr, 40);
        wait_quiet("t5");
        chk_eq("t5_writes", wr_addr.size() - w0, 1);

        // 6: reset during beat 2 of an eight-beat burst
        w0 = wr_addr.size();
        d0 = n_done;
        @(posedge clk); #1;
        push(1'b0, mk_instr(1, 1, 7'd60, 5'd8, 5'd7));
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.dma_we && (bus.dma_dat_addr == 7'd62);
        end
        chk_eq("t6_beat2_seen", seen, 1);
        #2 reset = 1'b0;
        #1 chk_eq("t6_reset_outs", outs(), 0);
        #1;
        push(1'b0, mk_instr(1, 1, 7'd90, 5'd4, 5'd0));
        push(1'b1, mk_instr(1, 1, 7'd100, 5'd6, 5'd0));
        @(negedge clk);
        chk_eq("t6_held_outs", outs(), 0);
        p0 = pop_b.size();
        #1 reset = 1'b1;
        wait_quiet("t6");
        chk_eq("t6_writes", wr_addr.size() - w0, 5);
        chk_eq("t6_first_pop", pop_b[p0], 0);
        chk_eq("t6_addr_a", wr_addr[w0 + 3], 90);
        chk_eq("t6_addr_b", wr_addr[w0 + 4], 100);
        chk_eq("t6_done", n_done - d0, 2);

        chk_eq("empty_never_popped", bad_pop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
